// File: rtl/rsa16_msg_ctrl.sv
// rsa16_msg_ctrl: message sequencer in front of the rsa16 modexp core.
// Buffers base words in a FIFO, launches the core once per word with the held
// key, waits for the core's end flag and returns results in input order on a
// valid/ready stream. Sticky error bits flag a zero modulus and a core that
// never acknowledges a start.
module rsa16_msg_ctrl #(
    parameter int DEPTH = 8,
    parameter int TMO   = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_key_wr,
    input  logic [15:0]              i_exp,
    input  logic [15:0]              i_N,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [15:0]              i_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [15:0]              o_data,
    output logic                     o_core_start,
    output logic [15:0]              o_core_base,
    output logic [15:0]              o_core_exp,
    output logic [15:0]              o_core_N,
    input  logic [15:0]              i_core_result,
    input  logic                     i_core_end,
    output logic                     o_busy,
    output logic [1:0]               o_err,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TMO + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_SETTLE,
        ST_OUT
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [15:0]     exp_q, exp_d;
    logic [15:0]     n_q, n_d;
    logic [15:0]     base_q, base_d;
    logic [15:0]     data_q, data_d;
    logic            valid_q, valid_d;
    logic            start_q, start_d;
    logic [1:0]      err_q, err_d;

    logic            push;
    logic            pop;
    logic            busy;

    // Full-ness is judged on the registered count, so a full FIFO never
    // accepts even if a pop happens in the same cycle.
    assign busy    = (count_q != '0) || (state_q != ST_IDLE);
    assign o_ready = (count_q != CW'(DEPTH));
    assign push    = i_valid && o_ready;
    assign pop     = (state_q == ST_IDLE) && (count_q != '0) && i_core_end;

    assign o_valid      = valid_q;
    assign o_data       = data_q;
    assign o_core_start = start_q;
    assign o_core_base  = base_q;
    assign o_core_exp   = exp_q;
    assign o_core_N     = n_q;
    assign o_busy       = busy;
    assign o_err        = err_q;
    assign o_count      = count_q;

    // FIFO storage: plain array without reset so it maps onto RAM.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    // Next-state logic for pointers, key registers and the job sequencer.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        tmo_d    = tmo_q;
        exp_d    = exp_q;
        n_d      = n_q;
        base_d   = base_q;
        data_d   = data_q;
        valid_d  = valid_q;
        start_d  = start_q;
        err_d    = err_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

        // Key changes mid-message would mix keys within one message, so a
        // write while busy is silently dropped.
        if (i_key_wr && !busy) begin
            if (i_N == 16'd0) begin
                err_d[0] = 1'b1;
            end else begin
                exp_d = i_exp;
                n_d   = i_N;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    base_d  = mem_q[rd_ptr_q];
                    start_d = 1'b1;
                    tmo_d   = '0;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (!i_core_end) begin
                    start_d = 1'b0;
                    state_d = ST_RUN;
                end else if (tmo_q == TW'(TMO - 1)) begin
                    // Core never acknowledged: drop this word and move on.
                    err_d[1] = 1'b1;
                    start_d  = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (i_core_end) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // The core's result register lands one cycle after end rises.
                data_d  = i_core_result;
                valid_d = 1'b1;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any job in flight.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            tmo_q    <= '0;
            exp_q    <= 16'd0;
            n_q      <= 16'd1;
            base_q   <= 16'd0;
            data_q   <= 16'd0;
            valid_q  <= 1'b0;
            start_q  <= 1'b0;
            err_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            tmo_q    <= tmo_d;
            exp_q    <= exp_d;
            n_q      <= n_d;
            base_q   <= base_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            start_q  <= start_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_rsa16_msg_ctrl.sv
// Directed testbench for rsa16_msg_ctrl with a behavioural rsa16 core model.
module tb_rsa16_msg_ctrl;

    localparam int DEPTH = 8;
    localparam int TMO   = 8;

    logic        clk = 1'b0;
    logic        rstn;
    logic        key_wr;
    logic [15:0] k_exp, k_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        o_valid;
    logic        ds_ready;
    logic [15:0] o_data;
    logic        o_core_start;
    logic [15:0] o_core_base, o_core_exp, o_core_N;
    logic [15:0] core_result;
    logic        core_end;
    logic        o_busy;
    logic [1:0]  o_err;
    logic [3:0]  o_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rsa16_msg_ctrl #(.DEPTH(DEPTH), .TMO(TMO)) dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .i_key_wr      (key_wr),
        .i_exp         (k_exp),
        .i_N           (k_n),
        .i_valid       (in_valid),
        .o_ready       (in_ready),
        .i_data        (in_data),
        .o_valid       (o_valid),
        .i_ready       (ds_ready),
        .o_data        (o_data),
        .o_core_start  (o_core_start),
        .o_core_base   (o_core_base),
        .o_core_exp    (o_core_exp),
        .o_core_N      (o_core_N),
        .i_core_result (core_result),
        .i_core_end    (core_end),
        .o_busy        (o_busy),
        .o_err         (o_err),
        .o_count       (o_count)
    );

    // ---------------- behavioural core model ----------------
    logic        core_run = 1'b0;
    logic        start_prev = 1'b0;
    logic        res_upd = 1'b0;
    logic [15:0] pend = 16'd0;
    int          lat = 0;
    int          core_lat = 3;
    bit          core_stall = 1'b0;
    bit          core_tie_high = 1'b0;
    int          launches = 0;

    function automatic logic [15:0] modexp(input logic [15:0] b, input logic [15:0] e,
                                           input logic [15:0] n);
        logic [31:0] r;
        logic [31:0] x;
        r = 32'd1 % {16'd0, n};
        x = {16'd0, b} % {16'd0, n};
        for (int i = 0; i < 16; i++) begin
            if (e[i]) r = (r * x) % {16'd0, n};
            x = (x * x) % {16'd0, n};
        end
        return r[15:0];
    endfunction

    assign core_end = core_tie_high ? 1'b1 : (!core_run && !core_stall);

    // Core launches only on a rising start edge; result register updates one
    // cycle after end rises.
    always @(posedge clk) begin
        start_prev <= o_core_start;
        res_upd    <= 1'b0;
        if (res_upd) core_result <= pend;
        if (!rstn) begin
            core_run <= 1'b0;
        end else if (!core_run && o_core_start && !start_prev && !core_tie_high) begin
            core_run <= 1'b1;
            lat      <= core_lat;
            pend     <= modexp(o_core_base, o_core_exp, o_core_N);
            launches <= launches + 1;
        end else if (core_run) begin
            if (lat == 0) begin
                core_run <= 1'b0;
                res_upd  <= 1'b1;
            end else begin
                lat <= lat - 1;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
        $display("push %0d (count now %0d)", d, o_count);
    endtask

    task automatic key_write(input logic [15:0] e, input logic [15:0] n);
        key_wr = 1'b1;
        k_exp  = e;
        k_n    = n;
        @(negedge clk);
        key_wr = 1'b0;
        $display("key write exp=%0d N=%0d -> core exp=%0d N=%0d err=%b", e, n,
                 o_core_exp, o_core_N, o_err);
    endtask

    task automatic get_result(input string tag, input logic [15:0] expv);
        int n = 0;
        while (!o_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_vld"}, {31'd0, o_valid}, 32'd1);
        check(tag, {16'd0, o_data}, {16'd0, expv});
        $display("result %s = %0d", tag, o_data);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_valid"}, {31'd0, o_valid}, 32'd0);
        check({tag, "_data"},  {16'd0, o_data}, 32'd0);
        check({tag, "_start"}, {31'd0, o_core_start}, 32'd0);
        check({tag, "_base"},  {16'd0, o_core_base}, 32'd0);
        check({tag, "_busy"},  {31'd0, o_busy}, 32'd0);
        check({tag, "_err"},   {30'd0, o_err}, 32'd0);
        check({tag, "_count"}, {28'd0, o_count}, 32'd0);
        check({tag, "_kexp"},  {16'd0, o_core_exp}, 32'd0);
        check({tag, "_kn"},    {16'd0, o_core_N}, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        bit stable;
        int launches_before;

        rstn     = 1'b0;
        key_wr   = 1'b0;
        k_exp    = 16'd0;
        k_n      = 16'd0;
        in_valid = 1'b0;
        in_data  = 16'd0;
        ds_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rstn = 1'b1;
        @(negedge clk);

        // 1: single word, 4^13 mod 497 = 445
        key_write(16'd13, 16'd497);
        check("key1_exp", {16'd0, o_core_exp}, 32'd13);
        check("key1_n",   {16'd0, o_core_N}, 32'd497);
        push(16'd4);
        get_result("t1", 16'd445);
        check("t1_busy", {31'd0, o_busy}, 32'd0);
        check("t1_err",  {30'd0, o_err}, 32'd0);

        // 2: back-to-back words under exp=10, N=1000
        key_write(16'd10, 16'd1000);
        push(16'd2);
        push(16'd3);
        push(16'd7);
        get_result("t2a", 16'd24);
        get_result("t2b", 16'd49);
        get_result("t2c", 16'd249);

        // 3: fill FIFO while the core is stalled
        core_stall = 1'b1;
        for (int i = 1; i <= DEPTH; i++) push(16'(i));
        check("full_count", {28'd0, o_count}, DEPTH);
        check("full_ready", {31'd0, in_ready}, 32'd0);
        push(16'd9);
        check("full_extra", {28'd0, o_count}, DEPTH);
        core_stall = 1'b0;
        get_result("f1", 16'd1);
        get_result("f2", 16'd24);
        get_result("f3", 16'd49);
        get_result("f4", 16'd576);
        get_result("f5", 16'd625);
        get_result("f6", 16'd176);
        get_result("f7", 16'd249);
        get_result("f8", 16'd824);
        repeat (20) @(negedge clk);
        check("fill_novalid", {31'd0, o_valid}, 32'd0);
        check("fill_empty",   {28'd0, o_count}, 32'd0);
        check("fill_idle",    {31'd0, o_busy}, 32'd0);

        // 4: downstream stall in OUT
        ds_ready = 1'b0;
        push(16'd2);
        push(16'd3);
        n = 0;
        while (!o_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        launches_before = launches;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!o_valid || o_data !== 16'd24 || o_core_start) stable = 1'b0;
        end
        check("hold_stable", {31'd0, stable}, 32'd1);
        check("hold_nolaunch", launches, launches_before);
        check("hold_count", {28'd0, o_count}, 32'd1);
        ds_ready = 1'b1;
        get_result("hold_rel", 16'd24);
        get_result("hold_next", 16'd49);

        // 5: key errors and writes while busy
        key_write(16'd5, 16'd0);
        check("kerr_err", {30'd0, o_err}, 32'd1);
        check("kerr_exp", {16'd0, o_core_exp}, 32'd10);
        check("kerr_n",   {16'd0, o_core_N}, 32'd1000);
        core_stall = 1'b1;
        push(16'd5);
        check("kbusy_busy", {31'd0, o_busy}, 32'd1);
        key_write(16'd3, 16'd7);
        key_write(16'd3, 16'd0);
        check("kbusy_exp", {16'd0, o_core_exp}, 32'd10);
        check("kbusy_n",   {16'd0, o_core_N}, 32'd1000);
        check("kbusy_err", {30'd0, o_err}, 32'd1);
        core_stall = 1'b0;
        get_result("kbusy_res", 16'd625);

        // 6: core never drops end -> timeout after TMO cycles in LAUNCH
        core_tie_high = 1'b1;
        push(16'd6);
        repeat (TMO) @(negedge clk);
        check("tmo_pre_err",   {31'd0, o_err[1]}, 32'd0);
        check("tmo_pre_start", {31'd0, o_core_start}, 32'd1);
        @(negedge clk);
        check("tmo_err",   {30'd0, o_err}, 32'd3);
        check("tmo_start", {31'd0, o_core_start}, 32'd0);
        check("tmo_busy",  {31'd0, o_busy}, 32'd0);
        check("tmo_count", {28'd0, o_count}, 32'd0);
        repeat (5) @(negedge clk);
        check("tmo_novalid", {31'd0, o_valid}, 32'd0);
        core_tie_high = 1'b0;

        // 7: async reset in the middle of RUN
        core_lat = 30;
        push(16'd7);
        n = 0;
        while (!o_core_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (o_core_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("run_busy",  {31'd0, o_busy}, 32'd1);
        check("run_start", {31'd0, o_core_start}, 32'd0);
        check("run_valid", {31'd0, o_valid}, 32'd0);
        #2 rstn = 1'b0;
        #1;
        $display("async reset asserted mid-job");
        check_reset_outputs("arst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
